cordic_polar_engine: RTL and testbench
======================================

Name: cordic_polar_engine

Overview:
- Parametrised iterative CORDIC engine; successor to the fixed 9-bit Cartesian-to-polar block.
- Adds selectable mode: vectoring (Cartesian→polar) or rotation (rotate vector by angle).
- Adds configurable data width, angle width and iteration count, plus a full START/BUSY/DONE handshake.
- Sits between the input capture registers and the display/result stage of the Cart2Polar datapath.

Parameters:
- DATA_W, 9: signed two's-complement width of X_IN/Y_IN.
- THETA_W, 8: binary-angle width; full circle = 2^THETA_W units.
- ITER, 8: number of micro-rotations, 1..16.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  request. Its rising edge is detected internally, so a level held for many cycles triggers once.
- MODE  in  1  0 = vectoring, 1 = rotation. Sampled with the accepted START.
- X_IN  in  DATA_W  signed X. Sampled with the accepted START.
- Y_IN  in  DATA_W  signed Y. Sampled with the accepted START.
- THETA_IN  in  THETA_W  rotation angle, binary angle. Used in rotation mode only.
- X_OUT  out  DATA_W+2  signed; magnitude (vectoring) or rotated X (rotation).
- Y_OUT  out  DATA_W+2  signed; residual Y (vectoring, ≈0) or rotated Y (rotation).
- THETA_OUT  out  THETA_W  atan2(Y,X) in binary angle (vectoring) or residual angle (rotation).
- BUSY  out  1  high while iterating.
- DONE  out  1  one-cycle pulse; outputs are valid and updated.

Behaviour:
- Reset (async, RST_N=0):
  - state=IDLE.
  - X_OUT, Y_OUT, THETA_OUT, BUSY, DONE = 0.
  - Edge-detect register = 0, so a START already high at reset release does not trigger.
- Datapath:
  - X/Y internal width is DATA_W+2, sign-extended, to absorb the CORDIC gain and the negation of the most negative input.
  - Z accumulator is 16-bit binary angle.
  - atan table: atan(2^-i)·65536/2π rounded, for i=0..15.
  - THETA_OUT = Z[15:16-THETA_W], rounded to nearest, wraps modulo the full circle.
  - THETA_IN is zero-extended into the top bits of Z.
- No gain compensation. Magnitudes carry K≈1.6468 for ITER≥6.
- States:
  - IDLE: on START rising edge, go to RUN and apply pre-rotation.
    - Vectoring: if X<0, negate X and Y and set Z = half-turn; else Z=0.
    - Rotation: if the top two angle bits are 01 or 10, negate X and Y and set Z = THETA − half-turn; else Z = THETA.
    - BUSY is set on this edge. Iteration counter i=0.
  - RUN: one micro-rotation per cycle, i = 0..ITER-1.
    - Vectoring: d = −sign(Y).
    - Rotation: d = sign(Z), with sign(0) = +.
    - Updates: X ← X − d·(Y>>>i); Y ← Y + d·(X>>>i); Z ← Z − d·atan[i]. Shifts are arithmetic.
    - After micro-rotation ITER-1: register the outputs, pulse DONE, clear BUSY, return to IDLE.
- Latency:
  - START edge accepted at clock edge k → DONE high in the cycle following edge k+ITER.
  - Back-to-back throughput is ITER+1 cycles.
- START edge during BUSY: ignored and not queued.
- START edge in the DONE-high cycle: accepted. State is already IDLE.
- Outputs hold their values until the next DONE. They never change mid-operation.
- Reset during RUN: immediate abort to reset values. No DONE is issued.
- Input X=Y=0 in vectoring mode: outputs X=0, Y=0, THETA_OUT = 0.

Test Plan:
- Reset, then vectoring with X=0, Y=100, START held high for 1 cycle:
  - DONE exactly ITER+1 cycles after the accepting edge.
  - X_OUT=164±2, Y_OUT=0±2, THETA_OUT=64±1.
- Vectoring with X=−100, Y=0:
  - X_OUT=164±2, THETA_OUT=128±1.
- Vectoring with X=60, Y=60:
  - X_OUT=140±2, THETA_OUT=32±1.
- Vectoring with X=−256, Y=−256:
  - X_OUT=596±3 with no overflow, THETA_OUT=160±1.
- Rotation with MODE=1, X=100, Y=0:
  - THETA=64 → X_OUT=0±2, Y_OUT=164±2.
  - THETA=128 → X_OUT=−164±2, Y_OUT=0±2.
- Handshake:
  - START held high for 20 cycles → exactly one DONE.
  - Second START edge during BUSY → ignored.
  - START in the DONE cycle → accepted; second DONE ITER+1 cycles later.
  - RST_N low during RUN → all outputs 0 and no DONE.

Source files
------------

// File: rtl/cordic_polar_engine.sv
// cordic_polar_engine: iterative CORDIC in vectoring (cartesian to polar)
// or rotation mode, with START edge detect and BUSY/DONE handshake.
module cordic_polar_engine #(
   parameter int DATA_W  = 9,
   parameter int THETA_W = 8,
   parameter int ITER    = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_start,
   input  logic                     i_mode,
   input  logic signed [DATA_W-1:0] i_x_in,
   input  logic signed [DATA_W-1:0] i_y_in,
   input  logic [THETA_W-1:0]       i_theta_in,
   output logic signed [DATA_W+1:0] o_x_out,
   output logic signed [DATA_W+1:0] o_y_out,
   output logic [THETA_W-1:0]       o_theta_out,
   output logic                     o_busy,
   output logic                     o_done
);

   localparam int XW = DATA_W + 2;
   localparam int ZW = 16;
   localparam int RB = (THETA_W < ZW) ? (ZW - 1 - THETA_W) : 0;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam logic [ZW-1:0] HALF = 16'h8000;
   localparam logic [3:0]    LAST = 4'(ITER - 1);

   localparam logic [ZW-1:0] ATAN [16] = '{
      16'd8192, 16'd4836, 16'd2555, 16'd1297,
      16'd651,  16'd326,  16'd163,  16'd81,
      16'd41,   16'd20,   16'd10,   16'd5,
      16'd3,    16'd1,    16'd1,    16'd0
   };

   logic [0:0]           r_state;
   logic                 r_start_lo;
   logic                 r_mode;
   logic                 r_zero;
   logic [3:0]           r_i;
   logic signed [XW-1:0] r_x;
   logic signed [XW-1:0] r_y;
   logic [ZW-1:0]        r_z;

   logic                 w_start_rise;
   logic signed [XW-1:0] w_x_ext;
   logic signed [XW-1:0] w_y_ext;
   logic [ZW-1:0]        w_theta_z;
   logic                 w_pre_neg;
   logic [ZW-1:0]        w_pre_z;
   logic                 w_d_pos;
   logic signed [XW-1:0] w_x_sh;
   logic signed [XW-1:0] w_y_sh;
   logic [ZW-1:0]        w_atan;
   logic signed [XW-1:0] w_x_nxt;
   logic signed [XW-1:0] w_y_nxt;
   logic [ZW-1:0]        w_z_nxt;
   logic                 w_rbit;
   logic [THETA_W-1:0]   w_theta_res;

   // r_start_lo is 0 after reset, so a START already high must drop first
   assign w_start_rise = i_start & r_start_lo;

   assign w_x_ext   = XW'(i_x_in);
   assign w_y_ext   = XW'(i_y_in);
   assign w_theta_z = ZW'(32'(i_theta_in) << (ZW - THETA_W));

   always_comb begin
      w_pre_neg = 1'b0;
      w_pre_z   = '0;
      if (i_mode) begin
         w_pre_neg = w_theta_z[ZW-1] ^ w_theta_z[ZW-2];
         w_pre_z   = w_pre_neg ? (w_theta_z - HALF) : w_theta_z;
      end else begin
         w_pre_neg = w_x_ext[XW-1];
         w_pre_z   = w_pre_neg ? HALF : '0;
      end
   end

   assign w_d_pos = r_mode ? ~r_z[ZW-1] : r_y[XW-1];
   assign w_x_sh  = r_x >>> r_i;
   assign w_y_sh  = r_y >>> r_i;
   assign w_atan  = ATAN[r_i];

   assign w_x_nxt = w_d_pos ? (r_x - w_y_sh) : (r_x + w_y_sh);
   assign w_y_nxt = w_d_pos ? (r_y + w_x_sh) : (r_y - w_x_sh);
   assign w_z_nxt = w_d_pos ? (r_z - w_atan) : (r_z + w_atan);

   assign w_rbit = (THETA_W < ZW) ? w_z_nxt[RB] : 1'b0;

   // zero vector has no defined angle; report 0 instead of the Z walk
   assign w_theta_res = r_zero ? '0 :
      (w_z_nxt[ZW-1 -: THETA_W] + THETA_W'(w_rbit));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_start_lo  <= 1'b0;
         r_mode      <= 1'b0;
         r_zero      <= 1'b0;
         r_i         <= '0;
         r_x         <= '0;
         r_y         <= '0;
         r_z         <= '0;
         o_x_out     <= '0;
         o_y_out     <= '0;
         o_theta_out <= '0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
      end else begin
         r_start_lo <= ~i_start;
         o_done     <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_start_rise) begin
                  r_state <= S_RUN;
                  o_busy  <= 1'b1;
                  r_i     <= '0;
                  r_mode  <= i_mode;
                  r_zero  <= ~i_mode & (i_x_in == '0)
                             & (i_y_in == '0);
                  r_x     <= w_pre_neg ? -w_x_ext : w_x_ext;
                  r_y     <= w_pre_neg ? -w_y_ext : w_y_ext;
                  r_z     <= w_pre_z;
               end
            end
            S_RUN: begin
               r_x <= w_x_nxt;
               r_y <= w_y_nxt;
               r_z <= w_z_nxt;
               r_i <= r_i + 4'd1;
               if (r_i == LAST) begin
                  o_x_out     <= w_x_nxt;
                  o_y_out     <= w_y_nxt;
                  o_theta_out <= w_theta_res;
                  o_done      <= 1'b1;
                  o_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_polar_engine.sv
// tb_cordic_polar_engine: scenario tasks against a real-arithmetic
// polar/rotation model with CORDIC gain and tolerance bands.
module tb_cordic_polar_engine;

   localparam int DW = 9;
   localparam int TW = 8;
   localparam int IT = 8;
   localparam int M  = 1 << TW;
   localparam real PI = 3.14159265358979;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic mode = 1'b0;
   logic signed [DW-1:0] x_in = '0;
   logic signed [DW-1:0] y_in = '0;
   logic [TW-1:0] theta_in = '0;
   logic signed [DW+1:0] x_out;
   logic signed [DW+1:0] y_out;
   logic [TW-1:0] theta_out;
   logic busy;
   logic done;

   int n_checks = 0;
   int n_pass = 0;
   real kgain;

   always #5 clk = ~clk;

   cordic_polar_engine #(
      .DATA_W (DW),
      .THETA_W(TW),
      .ITER   (IT)
   ) u_dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_start    (start),
      .i_mode     (mode),
      .i_x_in     (x_in),
      .i_y_in     (y_in),
      .i_theta_in (theta_in),
      .o_x_out    (x_out),
      .o_y_out    (y_out),
      .o_theta_out(theta_out),
      .o_busy     (busy),
      .o_done     (done)
   );

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int cdiff(input int a, input int b);
      int d;
      d = (a - b) % M;
      if (d < 0) d += M;
      if (d > M / 2) d = M - d;
      return d;
   endfunction

   function automatic real rabs(input real v);
      return (v < 0.0) ? -v : v;
   endfunction

   task automatic run_op(input logic m, input int x, input int y,
                         input int th, output int lat);
      @(negedge clk);
      mode = m;
      x_in = DW'(x);
      y_in = DW'(y);
      theta_in = TW'(th);
      start = 1'b1;
      lat = -1;
      for (int c = 1; c <= IT + 10; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_checks++;
      if ({x_out, y_out, theta_out} !== '0) begin
         $display("FAIL reset_data: got %0d %0d %0d want 0 0 0",
                  x_out, y_out, theta_out);
      end else n_pass++;
      n_checks++;
      if ({busy, done} !== 2'b00) begin
         $display("FAIL reset_flags: got busy=%b done=%b want 0 0",
                  busy, done);
      end else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_start_at_reset();
      int nd;
      @(negedge clk);
      rst_n = 1'b0;
      start = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      repeat (IT + 4) begin
         @(negedge clk);
         if (done) nd++;
      end
      start = 1'b0;
      n_checks++;
      if (nd !== 0) begin
         $display("FAIL start_at_reset: got %0d dones want 0", nd);
      end else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_vector_plan();
      int vx[4] = '{0, -100, 60, -256};
      int vy[4] = '{100, 0, 60, -256};
      int ex[4] = '{164, 164, 140, 596};
      int tx[4] = '{2, 2, 2, 3};
      int et[4] = '{64, 128, 32, 160};
      int lat;
      for (int k = 0; k < 4; k++) begin
         run_op(1'b0, vx[k], vy[k], 0, lat);
         n_checks++;
         if (lat !== IT + 1) begin
            $display("FAIL vec%0d_latency: got %0d want %0d",
                     k, lat, IT + 1);
         end else n_pass++;
         n_checks++;
         if (iabs(int'(x_out) - ex[k]) > tx[k]) begin
            $display("FAIL vec%0d_mag: got %0d want %0d+-%0d",
                     k, x_out, ex[k], tx[k]);
         end else n_pass++;
         n_checks++;
         if (cdiff(int'(theta_out), et[k]) > 1) begin
            $display("FAIL vec%0d_theta: got %0d want %0d+-1",
                     k, theta_out, et[k]);
         end else n_pass++;
         if (k == 0) begin
            n_checks++;
            if (iabs(int'(y_out)) > 2) begin
               $display("FAIL vec0_resid: got %0d want 0+-2", y_out);
            end else n_pass++;
         end
      end
   endtask

   task automatic test_rotation_plan();
      int th[2] = '{64, 128};
      int ex[2] = '{0, -164};
      int ey[2] = '{164, 0};
      int lat;
      for (int k = 0; k < 2; k++) begin
         run_op(1'b1, 100, 0, th[k], lat);
         n_checks++;
         if (lat !== IT + 1) begin
            $display("FAIL rot%0d_latency: got %0d want %0d",
                     k, lat, IT + 1);
         end else n_pass++;
         n_checks++;
         if (iabs(int'(x_out) - ex[k]) > 2) begin
            $display("FAIL rot%0d_x: got %0d want %0d+-2",
                     k, x_out, ex[k]);
         end else n_pass++;
         n_checks++;
         if (iabs(int'(y_out) - ey[k]) > 2) begin
            $display("FAIL rot%0d_y: got %0d want %0d+-2",
                     k, y_out, ey[k]);
         end else n_pass++;
      end
   endtask

   task automatic test_zero_vector();
      int lat;
      run_op(1'b1, 100, 0, 64, lat);
      run_op(1'b0, 0, 0, 0, lat);
      n_checks++;
      if ({x_out, y_out, theta_out} !== '0 || lat !== IT + 1) begin
         $display("FAIL zero_vec: got %0d %0d %0d lat=%0d want 0 0 0",
                  x_out, y_out, theta_out, lat);
      end else n_pass++;
   endtask

   task automatic test_random_vector();
      int x, y, lat, et;
      real mag, em, ytol;
      for (int n = 0; n < 30; n++) begin
         do begin
            x = int'($urandom_range(0, 511)) - 256;
            y = int'($urandom_range(0, 511)) - 256;
            mag = $sqrt(real'(x * x + y * y));
         end while (mag < 160.0);
         em = kgain * mag;
         ytol = em / real'(1 << (IT - 1)) + 3.0;
         et = int'($atan2(real'(y), real'(x)) * real'(M) / (2.0 * PI));
         run_op(1'b0, x, y, 0, lat);
         n_checks++;
         if (rabs(real'(int'(x_out)) - em) > 5.0 || lat !== IT + 1) begin
            $display("FAIL rvec_mag (%0d,%0d): got %0d lat=%0d want %0.1f",
                     x, y, x_out, lat, em);
         end else n_pass++;
         n_checks++;
         if (rabs(real'(int'(y_out))) > ytol) begin
            $display("FAIL rvec_resid (%0d,%0d): got %0d want |y|<=%0.1f",
                     x, y, y_out, ytol);
         end else n_pass++;
         n_checks++;
         if (cdiff(int'(theta_out), et) > 3) begin
            $display("FAIL rvec_theta (%0d,%0d): got %0d want %0d+-3",
                     x, y, theta_out, et);
         end else n_pass++;
      end
   endtask

   task automatic test_random_rotation();
      int x, y, th, lat;
      real a, ex, ey, tol;
      for (int n = 0; n < 30; n++) begin
         x = int'($urandom_range(0, 400)) - 200;
         y = int'($urandom_range(0, 400)) - 200;
         th = int'($urandom_range(0, M - 1));
         a = real'(th) * 2.0 * PI / real'(M);
         ex = kgain * (real'(x) * $cos(a) - real'(y) * $sin(a));
         ey = kgain * (real'(x) * $sin(a) + real'(y) * $cos(a));
         tol = 6.0 + kgain * $sqrt(real'(x * x + y * y)) / 64.0;
         run_op(1'b1, x, y, th, lat);
         n_checks++;
         if (rabs(real'(int'(x_out)) - ex) > tol || lat !== IT + 1) begin
            $display("FAIL rrot_x (%0d,%0d,%0d): got %0d lat=%0d want %0.1f",
                     x, y, th, x_out, lat, ex);
         end else n_pass++;
         n_checks++;
         if (rabs(real'(int'(y_out)) - ey) > tol) begin
            $display("FAIL rrot_y (%0d,%0d,%0d): got %0d want %0.1f",
                     x, y, th, y_out, ey);
         end else n_pass++;
         n_checks++;
         if (cdiff(int'(theta_out), 0) > 1) begin
            $display("FAIL rrot_resid (%0d,%0d,%0d): got %0d want 0+-1",
                     x, y, th, theta_out);
         end else n_pass++;
      end
   endtask

   task automatic test_start_held();
      int nd;
      @(negedge clk);
      mode = 1'b0;
      x_in = DW'(60);
      y_in = DW'(60);
      start = 1'b1;
      nd = 0;
      for (int c = 0; c < 20 + IT + 4; c++) begin
         @(negedge clk);
         if (c == 19) start = 1'b0;
         if (done) nd++;
      end
      n_checks++;
      if (nd !== 1) begin
         $display("FAIL start_held: got %0d dones want 1", nd);
      end else n_pass++;
   endtask

   task automatic test_busy_ignore();
      int lat, nd, chg;
      logic signed [DW+1:0] hx;
      logic [TW-1:0] ht;
      int tmp;
      run_op(1'b1, 100, 0, 128, tmp);
      hx = x_out;
      ht = theta_out;
      @(negedge clk);
      mode = 1'b0;
      x_in = DW'(0);
      y_in = DW'(100);
      start = 1'b1;
      lat = -1;
      chg = 0;
      for (int c = 1; c <= IT + 10; c++) begin
         @(negedge clk);
         if (done) begin
            lat = c;
            break;
         end
         if (x_out !== hx || theta_out !== ht) chg++;
         start = (c == 3);
         if (c == 3) begin
            mode = 1'b1;
            x_in = DW'(-100);
            y_in = DW'(0);
         end
      end
      start = 1'b0;
      n_checks++;
      if (lat !== IT + 1 || chg !== 0) begin
         $display("FAIL busy_hold: got lat=%0d changes=%0d want %0d 0",
                  lat, chg, IT + 1);
      end else n_pass++;
      n_checks++;
      if (cdiff(int'(theta_out), 64) > 1) begin
         $display("FAIL busy_result: got theta %0d want 64+-1", theta_out);
      end else n_pass++;
      nd = 0;
      repeat (2 * IT) begin
         @(negedge clk);
         if (done) nd++;
      end
      n_checks++;
      if (nd !== 0) begin
         $display("FAIL busy_ignore: got %0d extra dones want 0", nd);
      end else n_pass++;
   endtask

   task automatic test_back_to_back();
      int lat, lat2;
      run_op(1'b0, 0, 100, 0, lat);
      n_checks++;
      if (lat !== IT + 1) begin
         $display("FAIL b2b_first: got lat %0d want %0d", lat, IT + 1);
      end else n_pass++;
      mode = 1'b0;
      x_in = DW'(-100);
      y_in = DW'(0);
      start = 1'b1;
      lat2 = -1;
      for (int c = 1; c <= IT + 10; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            lat2 = c;
            break;
         end
      end
      n_checks++;
      if (lat2 !== IT + 1) begin
         $display("FAIL b2b_second: got lat %0d want %0d", lat2, IT + 1);
      end else n_pass++;
      n_checks++;
      if (cdiff(int'(theta_out), 128) > 1) begin
         $display("FAIL b2b_theta: got %0d want 128+-1", theta_out);
      end else n_pass++;
   endtask

   task automatic test_reset_abort();
      int lat, nd;
      run_op(1'b0, 60, 60, 0, lat);
      @(negedge clk);
      x_in = DW'(0);
      y_in = DW'(100);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({x_out, y_out, theta_out, busy, done} !== '0) begin
         $display("FAIL abort_clear: got %0d %0d %0d b=%b d=%b want 0",
                  x_out, y_out, theta_out, busy, done);
      end else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      repeat (IT + 4) begin
         @(negedge clk);
         if (done) nd++;
      end
      n_checks++;
      if (nd !== 0) begin
         $display("FAIL abort_nodone: got %0d dones want 0", nd);
      end else n_pass++;
   endtask

   initial begin
      real p;
      kgain = 1.0;
      p = 1.0;
      for (int i = 0; i < IT; i++) begin
         kgain = kgain * $sqrt(1.0 + p * p);
         p = p / 2.0;
      end
      test_reset();
      test_start_at_reset();
      test_vector_plan();
      test_rotation_plan();
      test_zero_vector();
      test_random_vector();
      test_random_rotation();
      test_start_held();
      test_busy_ignore();
      test_back_to_back();
      test_reset_abort();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
